level_pick_seq: RTL and testbench
=================================

// Module: level_pick_seq
// PURPOSE
//  Parametrised multi-pin lock-pick level controller; generalises the single-pin easy level.
//  Quantises the pick's vertical position into slots and draws a random target slot per pin.
//  Each pin sets when the pick is held in its target slot, with tension applied, for a frame count.
//  Tension slips are counted. Sits between the VGA/pick position logic and the game-level sequencer.
// PARAMETERS
//  NUM_SLOTS   16       number of vertical slots (>=2)
//  SLOT_H      28       slot height, pixels
//  Y_TOP       32       pick_y of the top edge of slot 0
//  NUM_PINS    3        pins to set in sequence (>=1)
//  HOLD_FRAMES 30       consecutive frame_ticks in target slot needed to set a pin (>=1)
//  MAX_SLIPS   3        tension slips allowed; reaching this count = fail (>=1)
//  SEED        16'hACE1 LFSR reset value (non-zero)
// PORTS
//  Clk           in   1        system clock
//  Reset         in   1        synchronous, active-high reset
//  level_start   in   1        1-cycle pulse: (re)start level from any state
//  frame_tick    in   1        1-cycle pulse once per video frame
//  pick_y        in   10       pick vertical pixel position
//  tension       in   1        1 = tension applied (player holding)
//  cur_slot      out  SW       registered current slot, SW=$clog2(NUM_SLOTS)
//  slot_valid    out  1        pick_y inside slot field
//  target_slot   out  SW       target of active pin (HEX debug)
//  pins_set      out  PW       pins set so far, PW=$clog2(NUM_PINS+1)
//  hold_cnt      out  HW       frames held in HOLD, HW=$clog2(HOLD_FRAMES+1)
//  slips         out  LW       slip count, LW=$clog2(MAX_SLIPS+1)
//  level_done    out  1        level: all pins set
//  level_fail    out  1        level: slips reached MAX_SLIPS
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, LFSR=SEED. level_start also clears counters (not LFSR).
//  Slot map, 1-cycle latency: slot k iff Y_TOP+k*SLOT_H <= pick_y <= Y_TOP+(k+1)*SLOT_H-1.
//    Ranges never overlap. Out of range: slot_valid=0 and cur_slot holds its last value.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every cycle, including IDLE.
//  Target draw (LOAD): t=lfsr[SW-1:0]; if t>=NUM_SLOTS then t-=NUM_SLOTS; registered into target_slot.
//  match = slot_valid & (cur_slot==target_slot) & tension.
//  FSM: IDLE -> (level_start) LOAD -> SEEK.
//   LOAD: 1 cycle.
//   SEEK: match -> HOLD with hold_cnt=0.
//   HOLD: frame_tick & match -> hold_cnt++; when hold_cnt reaches HOLD_FRAMES -> SET.
//         Slot lost or !slot_valid while tension still high -> SEEK, hold_cnt=0, no slip.
//         tension falls -> SEEK, hold_cnt=0, slips++; slips==MAX_SLIPS -> FAIL.
//   SET: 1 cycle, pins_set++. If pins_set==NUM_PINS -> DONE, else LOAD (fresh target).
//   DONE: level_done=1. FAIL: level_fail=1. Both hold until level_start or Reset.
//  Tension drop in SEEK is not a slip. A slip needs a tension drop in HOLD.
//  Simultaneous events:
//   - frame_tick with loss of match: loss wins, no increment.
//   - Tension drop with slot loss: counts as a slip.
//   - level_start wins over every transition: -> LOAD same cycle, counters cleared.
//  level_done and level_fail are never high together.
// STRUCTURE
//  Package level_pkg: pick_state_e enum {IDLE,LOAD,SEEK,HOLD,SET,DONE,FAIL}, LFSR tap constant.
//  Sub-module pick_slot_quant (pick_y -> cur_slot, slot_valid; generate comparator chain, no divider).
//  LFSR, counters and FSM live in level_pick_seq.
// TESTING
//  Use HOLD_FRAMES=2, NUM_PINS=2 unless noted.
//  1. Slot map: pick_y=32 -> 0; 59 -> 0; 60 -> 1; 479 -> 15; 31 and 480 -> slot_valid=0, cur_slot held.
//  2. Reset mid-HOLD -> next cycle IDLE, all outputs 0; LFSR=SEED.
//  3. Park pick on target with tension, 2 ticks per pin -> pins_set 1 then 2, level_done=1; fail stays 0.
//  4. In HOLD with hold_cnt=1, drop tension 3x -> slips=3, level_fail=1, done stays 0.
//  5. In HOLD, move one slot off at a frame_tick -> SEEK, hold_cnt=0, slips unchanged.
//  6. level_start while DONE -> LOAD; pins_set, slips, hold_cnt =0; new target < NUM_SLOTS (try NUM_SLOTS=12).

Source files
------------

// File: rtl/level_pkg.sv
// Shared types and constants for the multi-pin lock-pick level controller.
package level_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEEK,
    HOLD,
    SET,
    DONE,
    FAIL
  } pick_state_e;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/pick_slot_quant.sv
// Quantises pick_y into a registered slot index using a comparator chain.
module pick_slot_quant #(
  parameter int unsigned NUM_SLOTS = 16,
  parameter int unsigned SLOT_H    = 28,
  parameter int unsigned Y_TOP     = 32,
  localparam int unsigned SW       = $clog2(NUM_SLOTS)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [9:0]    i_pick_y,
  output logic [SW-1:0] o_cur_slot,
  output logic          o_slot_valid
);

  logic [NUM_SLOTS:0] w_ge;
  logic [SW-1:0]      w_slot;
  logic               w_in_field;
  logic [SW-1:0]      r_cur_slot;
  logic               r_slot_valid;

  // w_ge[k]: pick is at or below the top edge of slot k (k==NUM_SLOTS is the field end)
  for (genvar k = 0; k <= NUM_SLOTS; k++) begin : g_cmp
    localparam int unsigned LO = Y_TOP + 32'(k) * SLOT_H;
    assign w_ge[k] = (32'(i_pick_y) >= LO);
  end

  assign w_in_field = w_ge[0] & ~w_ge[NUM_SLOTS];

  always_comb begin
    w_slot = '0;
    for (int k = 1; k < NUM_SLOTS; k++) begin
      if (w_ge[k]) w_slot = SW'(k);
    end
  end

  // Out-of-field positions keep the last valid slot
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cur_slot   <= '0;
      r_slot_valid <= 1'b0;
    end else begin
      r_slot_valid <= w_in_field;
      if (w_in_field) r_cur_slot <= w_slot;
    end
  end

  assign o_cur_slot   = r_cur_slot;
  assign o_slot_valid = r_slot_valid;

endmodule

// File: rtl/level_pick_seq.sv
// Multi-pin lock-pick level: random target per pin, hold-to-set with tension, slip counting.
module level_pick_seq
  import level_pkg::*;
#(
  parameter int unsigned NUM_SLOTS   = 16,
  parameter int unsigned SLOT_H      = 28,
  parameter int unsigned Y_TOP       = 32,
  parameter int unsigned NUM_PINS    = 3,
  parameter int unsigned HOLD_FRAMES = 30,
  parameter int unsigned MAX_SLIPS   = 3,
  parameter logic [15:0] SEED        = 16'hACE1,
  localparam int unsigned SW         = $clog2(NUM_SLOTS),
  localparam int unsigned PW         = $clog2(NUM_PINS + 1),
  localparam int unsigned HW         = $clog2(HOLD_FRAMES + 1),
  localparam int unsigned LW         = $clog2(MAX_SLIPS + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_level_start,
  input  logic          i_frame_tick,
  input  logic [9:0]    i_pick_y,
  input  logic          i_tension,
  output logic [SW-1:0] o_cur_slot,
  output logic          o_slot_valid,
  output logic [SW-1:0] o_target_slot,
  output logic [PW-1:0] o_pins_set,
  output logic [HW-1:0] o_hold_cnt,
  output logic [LW-1:0] o_slips,
  output logic          o_level_done,
  output logic          o_level_fail
);

  pick_state_e   r_state, w_state_nxt;
  logic [15:0]   r_lfsr;
  logic [SW-1:0] r_target_slot, w_target_nxt, w_draw;
  logic [PW-1:0] r_pins_set, w_pins_nxt;
  logic [HW-1:0] r_hold_cnt, w_hold_nxt;
  logic [LW-1:0] r_slips, w_slips_nxt;
  logic          r_level_done, r_level_fail;
  logic          w_match;

  pick_slot_quant #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_H    (SLOT_H),
    .Y_TOP     (Y_TOP)
  ) u_quant (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_pick_y     (i_pick_y),
    .o_cur_slot   (o_cur_slot),
    .o_slot_valid (o_slot_valid)
  );

  // Fold the raw LFSR draw into 0..NUM_SLOTS-1
  always_comb begin
    w_draw = r_lfsr[SW-1:0];
    if (32'(r_lfsr[SW-1:0]) >= NUM_SLOTS) w_draw = SW'(32'(r_lfsr[SW-1:0]) - NUM_SLOTS);
  end

  assign w_match = o_slot_valid & (o_cur_slot == r_target_slot) & i_tension;

  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target_slot;
    w_pins_nxt   = r_pins_set;
    w_hold_nxt   = r_hold_cnt;
    w_slips_nxt  = r_slips;
    if (i_level_start) begin
      w_state_nxt = LOAD;
      w_pins_nxt  = '0;
      w_hold_nxt  = '0;
      w_slips_nxt = '0;
    end else begin
      case (r_state)
        IDLE: ;
        LOAD: begin
          w_target_nxt = w_draw;
          w_state_nxt  = SEEK;
        end
        SEEK: begin
          if (w_match) begin
            w_state_nxt = HOLD;
            w_hold_nxt  = '0;
          end
        end
        HOLD: begin
          // Tension drop takes priority over slot loss and counts as a slip
          if (!i_tension) begin
            w_hold_nxt  = '0;
            w_slips_nxt = r_slips + LW'(1);
            w_state_nxt = (w_slips_nxt == LW'(MAX_SLIPS)) ? FAIL : SEEK;
          end else if (!w_match) begin
            w_hold_nxt  = '0;
            w_state_nxt = SEEK;
          end else if (i_frame_tick) begin
            w_hold_nxt = r_hold_cnt + HW'(1);
            if (w_hold_nxt == HW'(HOLD_FRAMES)) w_state_nxt = SET;
          end
        end
        SET: begin
          w_pins_nxt  = r_pins_set + PW'(1);
          w_hold_nxt  = '0;
          w_state_nxt = (w_pins_nxt == PW'(NUM_PINS)) ? DONE : LOAD;
        end
        DONE: ;
        FAIL: ;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_lfsr        <= SEED;
      r_target_slot <= '0;
      r_pins_set    <= '0;
      r_hold_cnt    <= '0;
      r_slips       <= '0;
      r_level_done  <= 1'b0;
      r_level_fail  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_lfsr        <= lfsr_next(r_lfsr);
      r_target_slot <= w_target_nxt;
      r_pins_set    <= w_pins_nxt;
      r_hold_cnt    <= w_hold_nxt;
      r_slips       <= w_slips_nxt;
      r_level_done  <= (w_state_nxt == DONE);
      r_level_fail  <= (w_state_nxt == FAIL);
    end
  end

  assign o_target_slot = r_target_slot;
  assign o_pins_set    = r_pins_set;
  assign o_hold_cnt    = r_hold_cnt;
  assign o_slips       = r_slips;
  assign o_level_done  = r_level_done;
  assign o_level_fail  = r_level_fail;

endmodule

// File: tb/tb_level_pick_seq.sv
// Directed + randomized bench for level_pick_seq against a behavioural game-rule model.
module tb_level_pick_seq;

  localparam int unsigned NS   = 16;
  localparam int unsigned SH   = 28;
  localparam int unsigned YT   = 32;
  localparam int unsigned NP   = 2;
  localparam int unsigned HF   = 2;
  localparam int unsigned MS   = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  localparam int M_IDLE = 0, M_LOAD = 1, M_SEEK = 2, M_HOLD = 3,
                 M_SET  = 4, M_DONE = 5, M_FAIL = 6;

  logic       clk = 1'b0;
  logic       rst, ls, ft, ten;
  logic [9:0] y;

  logic [3:0] o_cur_slot, o_target_slot;
  logic       o_slot_valid, o_level_done, o_level_fail;
  logic [1:0] o_pins_set, o_hold_cnt, o_slips;

  logic [3:0] o12_cur_slot, o12_target_slot;
  logic       o12_slot_valid, o12_level_done, o12_level_fail;
  logic [1:0] o12_pins_set, o12_hold_cnt, o12_slips;

  always #5 clk = ~clk;

  level_pick_seq #(
    .NUM_SLOTS(NS), .SLOT_H(SH), .Y_TOP(YT), .NUM_PINS(NP),
    .HOLD_FRAMES(HF), .MAX_SLIPS(MS), .SEED(SEED)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_level_start(ls), .i_frame_tick(ft),
    .i_pick_y(y), .i_tension(ten),
    .o_cur_slot(o_cur_slot), .o_slot_valid(o_slot_valid), .o_target_slot(o_target_slot),
    .o_pins_set(o_pins_set), .o_hold_cnt(o_hold_cnt), .o_slips(o_slips),
    .o_level_done(o_level_done), .o_level_fail(o_level_fail)
  );

  level_pick_seq #(
    .NUM_SLOTS(12), .SLOT_H(SH), .Y_TOP(YT), .NUM_PINS(NP),
    .HOLD_FRAMES(HF), .MAX_SLIPS(MS), .SEED(SEED)
  ) dut12 (
    .i_clk(clk), .i_reset(rst), .i_level_start(ls), .i_frame_tick(ft),
    .i_pick_y(y), .i_tension(ten),
    .o_cur_slot(o12_cur_slot), .o_slot_valid(o12_slot_valid), .o_target_slot(o12_target_slot),
    .o_pins_set(o12_pins_set), .o_hold_cnt(o12_hold_cnt), .o_slips(o12_slips),
    .o_level_done(o12_level_done), .o_level_fail(o12_level_fail)
  );

  int checks = 0;
  int errors = 0;

  int          m_state, m_cur, m_valid, m_target, m_pins, m_hold, m_slips;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] ref_lfsr(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic int fold(input logic [15:0] v, input int ns);
    int t;
    t = int'(v) % 16;
    if (t >= ns) t = t - ns;
    return t;
  endfunction

  function automatic int ypos(input int slot);
    return int'(YT) + slot * int'(SH) + int'(SH) / 2;
  endfunction

  // Game rules evaluated once per clock edge on the values visible before the edge
  task automatic model_update();
    int  ns, nh, nsl, np, nt;
    bit  hit;
    if (rst) begin
      m_state = M_IDLE; m_cur = 0; m_valid = 0; m_target = 0;
      m_pins = 0; m_hold = 0; m_slips = 0; m_lfsr = SEED;
      return;
    end
    hit = (m_valid == 1) && (m_cur == m_target) && (ten == 1'b1);
    ns = m_state; nh = m_hold; nsl = m_slips; np = m_pins; nt = m_target;
    if (ls) begin
      ns = M_LOAD; nh = 0; nsl = 0; np = 0;
    end else if (m_state == M_LOAD) begin
      nt = fold(m_lfsr, NS);
      ns = M_SEEK;
    end else if (m_state == M_SEEK) begin
      if (hit) begin ns = M_HOLD; nh = 0; end
    end else if (m_state == M_HOLD) begin
      if (!ten) begin
        nsl = m_slips + 1; nh = 0;
        ns = (nsl == int'(MS)) ? M_FAIL : M_SEEK;
      end else if (!hit) begin
        ns = M_SEEK; nh = 0;
      end else if (ft) begin
        nh = m_hold + 1;
        if (nh == int'(HF)) ns = M_SET;
      end
    end else if (m_state == M_SET) begin
      np = m_pins + 1; nh = 0;
      ns = (np == int'(NP)) ? M_DONE : M_LOAD;
    end
    m_state = ns; m_hold = nh; m_slips = nsl; m_pins = np; m_target = nt;
    if (int'(y) >= int'(YT) && int'(y) < int'(YT + NS * SH)) begin
      m_valid = 1;
      m_cur = (int'(y) - int'(YT)) / int'(SH);
    end else begin
      m_valid = 0;
    end
    m_lfsr = ref_lfsr(m_lfsr);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("cur_slot",    32'(o_cur_slot),    32'(m_cur));
    chk("slot_valid",  32'(o_slot_valid),  32'(m_valid));
    chk("target_slot", 32'(o_target_slot), 32'(m_target));
    chk("pins_set",    32'(o_pins_set),    32'(m_pins));
    chk("hold_cnt",    32'(o_hold_cnt),    32'(m_hold));
    chk("slips",       32'(o_slips),       32'(m_slips));
    chk("level_done",  32'(o_level_done),  32'(m_state == M_DONE));
    chk("level_fail",  32'(o_level_fail),  32'(m_state == M_FAIL));
  endtask

  task automatic step(input logic r, input logic l, input logic f, input int yy, input logic t);
    rst = r; ls = l; ft = f; y = 10'(yy); ten = t;
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic reach_hold();
    for (int i = 0; i < 12 && m_state != M_HOLD; i++) step(0, 0, 0, ypos(m_target), 1);
  endtask

  task automatic play_to_done();
    for (int i = 0; i < 60 && m_state != M_DONE; i++) step(0, 0, 1, ypos(m_target), 1);
  endtask

  initial begin
    int exp12;
    int off;
    rst = 1'b1; ls = 1'b0; ft = 1'b0; ten = 1'b0; y = '0;
    m_state = M_IDLE; m_cur = 0; m_valid = 0; m_target = 0;
    m_pins = 0; m_hold = 0; m_slips = 0; m_lfsr = SEED;

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_done", 32'(o_level_done), 0);
    chk("rst_slot", 32'(o_cur_slot), 0);

    // Slot map boundaries
    step(0, 0, 0, 32, 0);  chk("map32",  32'({o_slot_valid, o_cur_slot}), 32'h10);
    step(0, 0, 0, 59, 0);  chk("map59",  32'({o_slot_valid, o_cur_slot}), 32'h10);
    step(0, 0, 0, 60, 0);  chk("map60",  32'({o_slot_valid, o_cur_slot}), 32'h11);
    step(0, 0, 0, 479, 0); chk("map479", 32'({o_slot_valid, o_cur_slot}), 32'h1F);
    step(0, 0, 0, 31, 0);  chk("map31",  32'({o_slot_valid, o_cur_slot}), 32'h0F);
    step(0, 0, 0, 480, 0); chk("map480", 32'({o_slot_valid, o_cur_slot}), 32'h0F);

    // Park on target with tension until both pins set
    step(0, 1, 0, 0, 0);
    play_to_done();
    chk("t3_done", 32'(o_level_done), 1);
    chk("t3_pins", 32'(o_pins_set), 2);
    chk("t3_fail", 32'(o_level_fail), 0);

    // Reset in the middle of HOLD, then confirm the LFSR restarted from SEED
    step(0, 1, 0, 0, 0);
    reach_hold();
    step(0, 0, 1, ypos(m_target), 1);
    chk("t2_hold1", 32'(o_hold_cnt), 1);
    step(1, 0, 0, 0, 0);
    chk("t2_rst_outs", 32'({o_cur_slot, o_slot_valid, o_target_slot, o_pins_set,
                            o_hold_cnt, o_slips, o_level_done, o_level_fail}), 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t2_seed_target", 32'(o_target_slot), 32'(fold(ref_lfsr(SEED), NS)));

    // Three tension drops in HOLD -> fail
    for (int s = 0; s < 3; s++) begin
      reach_hold();
      step(0, 0, 1, ypos(m_target), 1);
      chk("t4_hold1", 32'(o_hold_cnt), 1);
      step(0, 0, 0, ypos(m_target), 0);
    end
    chk("t4_slips", 32'(o_slips), 3);
    chk("t4_fail", 32'(o_level_fail), 1);
    chk("t4_done", 32'(o_level_done), 0);

    // Slide one slot off; the tick that sees the loss must not count
    step(0, 1, 0, 0, 0);
    reach_hold();
    off = (m_target == 15) ? 14 : m_target + 1;
    step(0, 0, 0, ypos(off), 1);
    step(0, 0, 1, ypos(off), 1);
    chk("t5_hold0", 32'(o_hold_cnt), 0);
    chk("t5_slips", 32'(o_slips), 0);

    // Restart from DONE; 12-slot instance must fold its draw into range
    play_to_done();
    chk("t6_done", 32'(o_level_done), 1);
    step(0, 1, 0, 0, 1);
    exp12 = fold(m_lfsr, 12);
    chk("t6_clr", 32'({o_pins_set, o_slips, o_hold_cnt, o_level_done}), 0);
    step(0, 0, 0, 0, 1);
    chk("t6_t12", 32'(o12_target_slot), 32'(exp12));
    chk("t6_t12_range", 32'(o12_target_slot < 4'd12), 1);

    // Randomized play against the model
    for (int i = 0; i < 3000; i++) begin
      logic r, l, f, t;
      int   yy, sel;
      r   = ($urandom_range(0, 399) == 0);
      l   = ($urandom_range(0, 59) == 0);
      f   = ($urandom_range(0, 3) == 0);
      t   = ($urandom_range(0, 15) != 0);
      sel = $urandom_range(0, 9);
      if (sel < 6)      yy = ypos(m_target);
      else if (sel < 7) yy = int'(YT) + m_target * int'(SH) + int'($urandom_range(0, 1)) * (int'(SH) - 1);
      else if (sel < 8) yy = ypos((m_target + 1) % int'(NS));
      else              yy = int'($urandom_range(0, 1023));
      step(r, l, f, yy, t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
